// File: rtl/memstream_pkg.sv
// memstream_pkg: shared read-latency, FIFO sizing and credit-counter widths
package memstream_pkg;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int CWIDTH = $clog2(RD_LATENCY + FIFO_DEPTH + 1);
  localparam int PWIDTH = $clog2(FIFO_DEPTH);
endpackage

// File: rtl/memstream_reader_fifo.sv
// memstream_reader_fifo: 4-entry synchronous FIFO with registered storage, count and head output
module memstream_reader_fifo
  import memstream_pkg::*;
#(
  parameter int W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [W-1:0]      din,
  input  logic              pop,
  output logic [W-1:0]      dout,
  output logic              valid,
  output logic [CWIDTH-1:0] count
);
  logic [W-1:0]      mem_q [FIFO_DEPTH];
  logic [W-1:0]      mem_d [FIFO_DEPTH];
  logic [PWIDTH-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CWIDTH-1:0] cnt_q, cnt_d;
  // next storage, pointers and occupancy; push and pop together leave the count unchanged
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wp_q] = din;
    wp_d  = wp_q + PWIDTH'(push);
    rp_d  = rp_q + PWIDTH'(pop);
    cnt_d = cnt_q + CWIDTH'(push) - CWIDTH'(pop);
  end
  // state registers, cleared so the head reads zero after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout  = mem_q[rp_q];
  assign valid = cnt_q != '0;
  assign count = cnt_q;
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && cnt_q == CWIDTH'(FIFO_DEPTH)));
endmodule

// File: rtl/memstream_reader.sv
// memstream_reader: cyclic block-RAM reader to AXI-Stream with credit-based prefetch (tlast via MEMSTREAM_READER_TLAST_EN)
module memstream_reader
  import memstream_pkg::*;
#(
  parameter int DWIDTH = 18,
  parameter int AWIDTH = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_rdq,
  output logic [DWIDTH-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready
`ifdef MEMSTREAM_READER_TLAST_EN
  ,
  output logic              m_axis_tlast
`endif
);
`ifdef MEMSTREAM_READER_TLAST_EN
  localparam int FW = DWIDTH + 1;
`else
  localparam int FW = DWIDTH;
`endif
  logic [AWIDTH-1:0]     addr_q, addr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [CWIDTH-1:0]     inflight, fifo_count;
  logic                  issue, at_end, pop;
  logic [FW-1:0]         fifo_din, fifo_dout;
  // credit check: reads in flight plus buffered beats may never exceed the FIFO size
  always_comb begin
    inflight = CWIDTH'($countones(vld_q));
    issue    = !rst && (inflight + fifo_count < CWIDTH'(FIFO_DEPTH));
    at_end   = addr_q == AWIDTH'(DEPTH - 1);
    addr_d   = !issue ? addr_q : at_end ? '0 : addr_q + AWIDTH'(1);
    vld_d    = {vld_q[RD_LATENCY-2:0], issue};
    pop      = m_axis_tvalid && m_axis_tready;
  end
  // address counter and issue-flag pipeline matching the memory read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      vld_q  <= '0;
    end else begin
      addr_q <= addr_d;
      vld_q  <= vld_d;
    end
  end
`ifdef MEMSTREAM_READER_TLAST_EN
  logic [RD_LATENCY-1:0] lst_q, lst_d;
  // last flag rides alongside the issue flag so it meets its data word
  always_comb begin
    lst_d = {lst_q[RD_LATENCY-2:0], issue && at_end};
  end
  // last-flag pipeline register
  always_ff @(posedge clk) begin
    if (rst) lst_q <= '0;
    else lst_q <= lst_d;
  end
  assign fifo_din     = {lst_q[RD_LATENCY-1], mem_rdq};
  assign m_axis_tlast = fifo_dout[DWIDTH];
`else
  assign fifo_din = mem_rdq;
`endif
  memstream_reader_fifo #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_q[RD_LATENCY-1]),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (m_axis_tvalid),
    .count (fifo_count)
  );
  assign m_axis_tdata = fifo_dout[DWIDTH-1:0];
  assign mem_addr     = addr_q;
  assign mem_we       = 1'b0;
endmodule

// File: tb/tb_memstream_reader.sv
// tb_memstream_reader: scoreboard bench for memstream_reader (DEPTH=8 main instance, DEPTH=1 side instance)
module tb_memstream_reader;
  localparam int DW = 18;
  localparam int AW = 10;
  localparam int D  = 8;
  logic clk = 0;
  logic rst = 1;
  logic tready = 0;
  logic tready1 = 1;
  logic [AW-1:0] addr, addr1;
  logic we, we1;
  logic [DW-1:0] rd1, rdq, rdq1, tdata, tdata1;
  logic tvalid, tvalid1;
`ifdef MEMSTREAM_READER_TLAST_EN
  logic tlast, tlast1;
`endif
  logic [DW-1:0] mem [D];
  logic [DW:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  int issued, accepted, beats1;
  logic [AW-1:0] last_addr;
  logic stalled;
  logic [DW-1:0] held;

  always #5 clk = ~clk;

  initial for (int i = 0; i < D; i++) mem[i] = 18'h01000 | 18'(i);
  always @(posedge clk) begin
    rd1 <= mem[addr[2:0]];
    rdq <= rd1;
  end
  assign rdq1 = 18'h002A5;

  memstream_reader #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .mem_addr(addr), .mem_we(we), .mem_rdq(rdq),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready)
`ifdef MEMSTREAM_READER_TLAST_EN
    , .m_axis_tlast(tlast)
`endif
  );

  memstream_reader #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .mem_addr(addr1), .mem_we(we1), .mem_rdq(rdq1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready1)
`ifdef MEMSTREAM_READER_TLAST_EN
    , .m_axis_tlast(tlast1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic restart();
    exp_q.delete();
    for (int k = 0; k < 600; k++) exp_q.push_back({k % 8 == 7, 18'h01000 | 18'(k % 8)});
  endtask

  always @(negedge clk) begin
    if (rst) begin
      issued = 0;
      accepted = 0;
      last_addr = '0;
      stalled = 0;
    end else begin
      if (addr != last_addr) issued++;
      last_addr = addr;
      chk("occupancy_le4", 32'((issued - accepted) <= 4), 1);
      if (stalled) begin
        chk("hold_valid", tvalid, 1);
        chk("hold_data", tdata, held);
      end
      if (tvalid && tready) begin
        accepted++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got beat %0h expected none", tdata);
        end else begin
          logic [DW:0] e;
          e = exp_q.pop_front();
          chk("beat_data", tdata, e[DW-1:0]);
`ifdef MEMSTREAM_READER_TLAST_EN
          chk("beat_last", tlast, e[DW]);
`endif
        end
      end
      stalled = tvalid && !tready;
      held = tdata;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("d1_addr", addr1, 0);
      if (tvalid1) begin
        beats1++;
        chk("d1_data", tdata1, 18'h002A5);
`ifdef MEMSTREAM_READER_TLAST_EN
        chk("d1_last", tlast1, 1);
`endif
      end
    end
  end

  initial begin
    beats1 = 0;
    restart();
    rst = 1;
    tready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_valid", tvalid, 0);
    chk("rst_data", tdata, 0);
    rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("pre_valid", tvalid, 0);
    end
    @(negedge clk);
    chk("first_valid", tvalid, 1);
    chk("first_data", tdata, 18'h01000);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("stream_valid", tvalid, 1);
    end
    @(posedge clk);
    #1 tready = 0;
    repeat (10) @(posedge clk);
    #1 rst = 1;
    restart();
    @(posedge clk);
    #1 rst = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_pre_valid", tvalid, 0);
    end
    @(negedge clk);
    chk("rst_first_valid", tvalid, 1);
    chk("rst_first_data", tdata, 18'h01000);
    repeat (16) @(negedge clk);
    chk("stall_addr", addr, 4);
    chk("stall_valid", tvalid, 1);
    chk("stall_data", tdata, 18'h01000);
    @(posedge clk);
    #1 tready = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("release_valid", tvalid, 1);
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1 tready = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1 tready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("accepted_min", 32'(accepted >= 100), 1);
    chk("d1_beats_min", 32'(beats1 >= 100), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
